seg7_display_mux: RTL and testbench

Multiplexed driver for a common-anode seven-segment display; the output-side counterpart of the board's push-button input path. It latches a hex value on a single-cycle `load` strobe, such as a debounced button pulse or a result-valid strobe from the array. It then scans the digits one at a time with a fixed refresh period and inserts a blanking gap between digits to suppress ghosting. All outputs are registered, active-low, and drive the board pins directly.

---
 rtl/seg7_display_mux_if.sv | 14 +
 rtl/seg7_display_mux.sv | 94 +++++++++
 tb/tb_seg7_display_mux.sv | 118 +++++++++++
 3 files changed

// File: rtl/seg7_display_mux_if.sv
// seg7_display_mux_if: data/strobe inputs and active-low pin outputs of the seven-segment driver.
interface seg7_display_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;

    modport master (output value, dp_in, load, input an, seg, dp);
    modport slave  (input value, dp_in, load, output an, seg, dp);
endinterface

// File: rtl/seg7_display_mux.sv
// seg7_display_mux: multiplexed common-anode seven-segment driver with blanking gaps.
// Define SEG7_LZ_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module seg7_display_mux #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    seg7_display_mux_if.slave bus
);
    localparam int MAXV = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
    // One extra count of headroom: reset loads BLANK_CYCLES itself, not BLANK_CYCLES-1.
    localparam int CW = $clog2(MAXV + 1);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [IW-1:0]       idx, idx_n;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   an_q, an_n;
    logic [6:0]          seg_q, seg_n;
    logic                dp_q, dp_n;
    logic [3:0]          nib;
    logic                lz;

    assign nib = shadow_val[4*idx +: 4];
`ifdef SEG7_LZ_BLANK_EN
    assign lz = (idx != '0) && ((shadow_val >> (4*idx)) == '0);
`else
    assign lz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= CW'(BLANK_CYCLES);
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            an_q  <= an_n;
            seg_q <= seg_n;
            dp_q  <= dp_n;
            if (bus.load) begin
                shadow_val <= bus.value;
                shadow_dp  <= bus.dp_in;
            end
        end
    end

    // Outputs are only recomputed on the BLANK/SHOW boundaries, so they stay frozen within a state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt - 1'b1;
        idx_n   = idx;
        an_n    = an_q;
        seg_n   = seg_q;
        dp_n    = dp_q;
        if (cnt == '0) begin
            if (state == BLANK) begin
                state_n = SHOW;
                cnt_n   = CW'(REFRESH_DIV - 1);
                an_n    = ~(DIGITS'(1) << idx);
                seg_n   = lz ? 7'h7F : HEX[nib];
                dp_n    = ~shadow_dp[idx];
            end else begin
                state_n = BLANK;
                cnt_n   = CW'(BLANK_CYCLES - 1);
                idx_n   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
                an_n    = '1;
                seg_n   = 7'h7F;
                dp_n    = 1'b1;
            end
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg7_display_mux.sv
// tb_seg7_display_mux: directed scenarios plus random loads/resets, checked every cycle
// against a time-slot model (DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, 24-cycle frame).
module tb_seg7_display_mux;
    localparam int D = 4, R = 4, B = 2, SLOT = R + B;
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_display_mux_if #(.DIGITS(D)) bus ();
    seg7_display_mux #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0, checks = 0;
    int n = 0;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // n counts edges since reset release; each digit owns a 6-cycle slot: 2 blank then 4 lit.
    task automatic model_edge(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        int ph, dg;
        logic [3:0] nib;
        if (r) begin
            n = 0; m_val = '0; m_dp = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            n++;
            ph = (n - 1) % SLOT;
            dg = ((n - 1) / SLOT) % D;
            if (ph == B) begin
                nib = 4'((m_val >> (4 * dg)) & 16'hF);
                exp_an = 4'hF;
                exp_an[dg] = 1'b0;
                exp_seg = GLYPH[nib];
`ifdef SEG7_LZ_BLANK_EN
                if (dg != 0 && (m_val >> (4 * dg)) == 16'h0) exp_seg = 7'h7F;
`endif
                exp_dp = ~m_dp[dg];
            end else if (ph == 0) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end
            if (l) begin
                m_val = v; m_dp = d;
            end
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        rst = r; bus.load = l; bus.value = v; bus.dp_in = d;
        @(posedge clk);
        model_edge(r, l, v, d);
        @(negedge clk);
        check("an", bus.an, exp_an);
        check("seg", bus.seg, exp_seg);
        check("dp", bus.dp, exp_dp);
        check("an_onehot", 32'($countones(~bus.an) <= 1), 1);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    // Advance until the next edge lands one cycle into digit dg's lit interval.
    task automatic wait_show(input int dg);
        int i;
        for (i = 0; i < 200 && !((n % SLOT) == B + 1 && ((n / SLOT) % D) == dg); i++)
            step(1'b0, 1'b0, 16'h0, 4'h0);
        check("sync_timeout", 32'(i < 200), 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(2);
        check("first_show_an", bus.an, 4'hF);
        idle(1);
        check("first_show_seg", bus.seg, 7'h40);
        idle(5);
        step(1'b0, 1'b1, 16'h1234, 4'h0);
        idle(50);
        wait_show(1);
        step(1'b0, 1'b1, 16'hFFFF, 4'h0);
        idle(30);
        step(1'b0, 1'b1, 16'h1234, 4'b0100);
        idle(50);
        step(1'b0, 1'b1, 16'h0050, 4'h0);
        idle(50);
        wait_show(2);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        check("shadow_after_rst", dut.shadow_val, 16'h0);
        idle(10);
        for (int i = 0; i < 1500; i++) begin
            logic r, l;
            r = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 7) == 0);
            step(r, l, 16'($urandom), 4'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
